rr_mux_scheduler: RTL and testbench

Four-channel round-robin scheduler that buffers one 4-bit word per channel and generates the 2-bit select for the 4-to-1 multiplexer. It forwards the selected word on a single valid/ready output stream. It sits directly upstream of `mux_4to1`: it produces the `sel` code and the registered result of the mux path, so four independent producers can share one 4-bit consumer fairly.

---
 rtl/rr_mux_scheduler_pkg.sv | 24 ++
 rtl/mux_4to1.sv | 32 +++
 rtl/rr_pick4.sv | 29 ++
 rtl/rr_mux_scheduler.sv | 107 ++++++++++
 tb/tb_rr_mux_scheduler.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/rr_mux_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module  : rr_mux_scheduler_pkg
// Purpose : Shared channel codes, widths and slot-FSM encodings for the
//           round-robin 4-to-1 mux scheduler.
// Rev     : 1.0
// ============================================================================
package rr_mux_scheduler_pkg;

    localparam int MUX_SEL_W = 2;
    localparam int MUX_NCH   = 4;

    localparam logic [MUX_SEL_W-1:0] CH_A = 2'd0;
    localparam logic [MUX_SEL_W-1:0] CH_B = 2'd1;
    localparam logic [MUX_SEL_W-1:0] CH_C = 2'd2;
    localparam logic [MUX_SEL_W-1:0] CH_D = 2'd3;

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    typedef logic [MUX_SEL_W-1:0] ch_idx_t;

endpackage : rr_mux_scheduler_pkg
`default_nettype wire

// File: rtl/mux_4to1.sv
`default_nettype none
// ============================================================================
// Module  : mux_4to1
// Purpose : Combinational 4-to-1 multiplexer, 00=a 01=b 10=c 11=d.
// Rev     : 1.0
// ============================================================================
module mux_4to1
    import rr_mux_scheduler_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic [WIDTH-1:0]     c,
    input  logic [WIDTH-1:0]     d,
    input  logic [MUX_SEL_W-1:0] sel,
    output logic [WIDTH-1:0]     y
);

    always_comb begin
        y = a;
        case (sel)
            CH_A:    y = a;
            CH_B:    y = b;
            CH_C:    y = c;
            CH_D:    y = d;
            default: y = a;
        endcase
    end

endmodule : mux_4to1
`default_nettype wire

// File: rtl/rr_pick4.sv
`default_nettype none
// ============================================================================
// Module  : rr_pick4
// Purpose : Combinational round-robin picker; searches ptr+1..ptr+4 mod 4.
// Rev     : 1.0
// ============================================================================
module rr_pick4
    import rr_mux_scheduler_pkg::*;
(
    input  logic [MUX_NCH-1:0]   req,
    input  logic [MUX_SEL_W-1:0] ptr,
    output logic [MUX_SEL_W-1:0] gnt_idx,
    output logic                 any
);

    // Walk from the farthest candidate back to the nearest so the nearest
    // requester after ptr wins; offset 4 wraps to ptr itself (lowest priority).
    always_comb begin
        gnt_idx = ptr;
        any     = |req;
        for (int k = MUX_NCH; k >= 1; k--) begin
            if (req[ptr + MUX_SEL_W'(k)]) begin
                gnt_idx = ptr + MUX_SEL_W'(k);
            end
        end
    end

endmodule : rr_pick4
`default_nettype wire

// File: rtl/rr_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : rr_mux_scheduler
// Purpose : Four-channel round-robin scheduler with one-word holding buffers
//           feeding a registered valid/ready output through mux_4to1.
// Rev     : 1.0
// ============================================================================
module rr_mux_scheduler
    import rr_mux_scheduler_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     a_in,
    input  logic [WIDTH-1:0]     b_in,
    input  logic [WIDTH-1:0]     c_in,
    input  logic [WIDTH-1:0]     d_in,
    input  logic [MUX_NCH-1:0]   in_valid,
    output logic [MUX_NCH-1:0]   in_ready,
    output logic [MUX_SEL_W-1:0] sel,
    output logic [WIDTH-1:0]     out,
    output logic                 out_valid,
    input  logic                 out_ready
);

    logic [WIDTH-1:0]     r_hold [MUX_NCH];
    logic [MUX_NCH-1:0]   r_pend;
    logic [MUX_SEL_W-1:0] r_ptr;
    logic [MUX_SEL_W-1:0] r_sel;
    logic [WIDTH-1:0]     r_out;
    logic [0:0]           r_state;

    logic [WIDTH-1:0]     w_din [MUX_NCH];
    logic [MUX_SEL_W-1:0] w_gnt_idx;
    logic                 w_any;
    logic                 w_free;
    logic                 w_grant;
    logic [WIDTH-1:0]     w_mux_y;

    assign w_din[0] = a_in;
    assign w_din[1] = b_in;
    assign w_din[2] = c_in;
    assign w_din[3] = d_in;

    rr_pick4 u_pick (
        .req     (r_pend),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    mux_4to1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .a   (r_hold[0]),
        .b   (r_hold[1]),
        .c   (r_hold[2]),
        .d   (r_hold[3]),
        .sel (w_gnt_idx),
        .y   (w_mux_y)
    );

    assign w_free  = (r_state == ST_EMPTY) || out_ready;
    assign w_grant = w_free && w_any;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend  <= '0;
            r_ptr   <= CH_D;
            r_sel   <= CH_A;
            r_out   <= '0;
            r_state <= ST_EMPTY;
            for (int i = 0; i < MUX_NCH; i++) begin
                r_hold[i] <= '0;
            end
        end else begin
            // A pending channel is never ready, so load and grant never collide.
            for (int i = 0; i < MUX_NCH; i++) begin
                if (in_valid[i] && !r_pend[i]) begin
                    r_hold[i] <= w_din[i];
                    r_pend[i] <= 1'b1;
                end else if (w_grant && (w_gnt_idx == MUX_SEL_W'(i))) begin
                    r_pend[i] <= 1'b0;
                end
            end

            if (w_free) begin
                if (w_any) begin
                    r_out   <= w_mux_y;
                    r_sel   <= w_gnt_idx;
                    r_ptr   <= w_gnt_idx;
                    r_state <= ST_FULL;
                end else begin
                    r_state <= ST_EMPTY;
                end
            end
        end
    end

    assign in_ready  = ~r_pend;
    assign sel       = r_sel;
    assign out       = r_out;
    assign out_valid = (r_state == ST_FULL);

endmodule : rr_mux_scheduler
`default_nettype wire

// File: tb/tb_rr_mux_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_rr_mux_scheduler
// Purpose : Scoreboard bench for rr_mux_scheduler against a cycle model.
// Rev     : 1.0
// ============================================================================
module tb_rr_mux_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] a_in = '0, b_in = '0, c_in = '0, d_in = '0;
    logic [3:0] in_valid = '0;
    logic [3:0] in_ready;
    logic [1:0] sel;
    logic [3:0] out;
    logic       out_valid;
    logic       out_ready = 1'b1;

    int n_chk  = 0;
    int n_pass = 0;

    logic [5:0] sb_q [$];
    logic [3:0] m_hold [4];
    logic [3:0] m_pend;
    logic [1:0] m_ptr;
    logic       m_full;

    always #5 clk = ~clk;

    rr_mux_scheduler #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .c_in      (c_in),
        .d_in      (d_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    function automatic void model_reset();
        m_pend = '0;
        m_ptr  = 2'd3;
        m_full = 1'b0;
        for (int i = 0; i < 4; i++) m_hold[i] = '0;
        sb_q.delete();
    endfunction

    // One clock: consume DUT handshake, advance the model, then compare.
    task automatic step();
        logic [3:0] acc;
        logic [3:0] din [4];
        logic       found;
        logic [1:0] g, idx;
        logic [5:0] exp_w;
        din = '{a_in, b_in, c_in, d_in};
        if (out_valid === 1'b1 && out_ready) begin
            if (sb_q.size() == 0) check("sb_underflow", 32'd0, 32'd1);
            else begin
                exp_w = sb_q.pop_front();
                check("sb_word", {26'd0, sel, out}, {26'd0, exp_w});
            end
        end
        acc   = in_valid & ~m_pend;
        found = 1'b0;
        g     = 2'd0;
        if (!m_full || out_ready) begin
            for (int k = 1; k <= 4; k++) begin
                idx = m_ptr + 2'(k);
                if (!found && m_pend[idx]) begin
                    found = 1'b1;
                    g     = idx;
                end
            end
            if (found) begin
                sb_q.push_back({g, m_hold[g]});
                m_pend[g] = 1'b0;
                m_ptr     = g;
                m_full    = 1'b1;
            end else begin
                m_full = 1'b0;
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                m_hold[i] = din[i];
                m_pend[i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("out_valid", {31'd0, out_valid}, {31'd0, m_full});
        check("in_ready", {28'd0, in_ready}, {28'd0, ~m_pend});
    endtask

    // Reset asserted mid-cycle; outputs must clear before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_out", {28'd0, out}, 32'd0);
        check("rst_sel", {30'd0, sel}, 32'd0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_ready", {28'd0, in_ready}, 32'hF);
        model_reset();
        in_valid = '0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        in_valid  = '0;
        out_ready = 1'b1;
        repeat (6) step();
        check("drain_q", sb_q.size(), 32'd0);
    endtask

    initial begin
        model_reset();
        do_reset();

        // Single word on channel b
        b_in = 4'h5; in_valid = 4'b0010; step();
        in_valid = '0; step();
        check("first_out", {28'd0, out}, 32'h5);
        check("first_sel", {30'd0, sel}, 32'h1);
        drain();

        // All four channels in one cycle
        do_reset();
        a_in = 4'h1; b_in = 4'h2; c_in = 4'h3; d_in = 4'h4;
        in_valid = 4'b1111; step();
        in_valid = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            check("burst_sel", {30'd0, sel}, i);
            check("burst_out", {28'd0, out}, i + 1);
        end
        step();
        check("burst_end", {31'd0, out_valid}, 32'd0);
        drain();

        // Backpressure with 4'hA held on out
        do_reset();
        out_ready = 1'b0;
        a_in = 4'hA; in_valid = 4'b0001; step();
        b_in = 4'hB; c_in = 4'hC; in_valid = 4'b0110; step();
        in_valid = '0;
        repeat (5) begin
            step();
            check("bp_out", {28'd0, out}, 32'hA);
            check("bp_sel", {30'd0, sel}, 32'd0);
        end
        out_ready = 1'b1;
        drain();

        // Fairness: a and d refilled continuously after a grant of a
        do_reset();
        a_in = 4'h7; in_valid = 4'b0001; step();
        in_valid = '0; step();
        in_valid = 4'b1001;
        for (int i = 0; i < 16; i++) begin
            a_in = 4'(i); d_in = 4'(15 - i);
            step();
            check("fair_no_c", {31'd0, (out_valid && sel == 2'd2)}, 32'd0);
        end
        drain();

        // Reset in the middle of a stalled stream
        out_ready = 1'b0;
        a_in = 4'h1; b_in = 4'h2; c_in = 4'h3; d_in = 4'h4;
        in_valid = 4'b1111; step();
        in_valid = '0; step();
        do_reset();
        out_ready = 1'b1;
        a_in = 4'h9; c_in = 4'h6; in_valid = 4'b0101; step();
        in_valid = '0; step();
        check("post_rst_sel", {30'd0, sel}, 32'd0);
        check("post_rst_out", {28'd0, out}, 32'h9);
        drain();

        // Channel a held valid: accepted every other cycle
        in_valid = 4'b0001;
        for (int i = 0; i < 12; i++) begin
            a_in = 4'(i + 3);
            step();
        end
        drain();

        // Random traffic and backpressure
        for (int i = 0; i < 300; i++) begin
            in_valid  = 4'($urandom_range(0, 15));
            a_in      = 4'($urandom); b_in = 4'($urandom);
            c_in      = 4'($urandom); d_in = 4'($urandom);
            out_ready = 1'($urandom_range(0, 3) != 0);
            step();
        end
        drain();
        check("final_valid", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_rr_mux_scheduler
`default_nettype wire
